// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared definitions for the memory-access stage.
//   MEM            - core sequencer state value in which the stage is active
//   mem_fsm_t      - stage FSM state encoding
//   ld_kind_t      - load extract/extend selector latched at request time
//   instructions_t - decoded instruction flags consumed by this stage
//   load_kind()    - maps a decoded instruction to its load kind
//   is_misaligned() - alignment rule for halfword and word accesses
package memory_access_pkg;

  localparam logic [2:0] MEM       = 3'd3;
  localparam int         NUM_LANES = 4;
  localparam int         LANE_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } mem_fsm_t;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_BU = 3'd1,
    LD_H  = 3'd2,
    LD_HU = 3'd3,
    LD_W  = 3'd4
  } ld_kind_t;

  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic flw;
    logic sb;
    logic sh;
    logic sw;
    logic fsw;
  } instructions_t;

  function automatic ld_kind_t load_kind(input instructions_t i);
    if (i.lb)       return LD_B;
    else if (i.lbu) return LD_BU;
    else if (i.lh)  return LD_H;
    else if (i.lhu) return LD_HU;
    else            return LD_W;
  endfunction

  function automatic logic is_misaligned(input instructions_t i, input logic [1:0] off);
    logic half, word;
    half = i.lh | i.lhu | i.sh;
    word = i.lw | i.flw | i.sw | i.fsw;
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: data-memory request/response bus.
//   master (stage side): drives dmem_req_valid/addr/we/wdata/wstrb,
//                        samples dmem_req_ready, dmem_rvalid, dmem_rdata.
//   slave  (memory side): the reverse.
interface memory_access_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access_load_align.sv
// load_align: combinational lane extract and sign/zero extension of a
// returned memory word.
//   kind  in  load kind (byte/half/word, signed/unsigned)
//   off   in  byte offset of the access within the word
//   rdata in  raw read word
//   value out extended load result
module load_align
  import memory_access_pkg::*;
(
  input  ld_kind_t    kind,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[8*off +: 8];
    half_v = rdata[16*off[1] +: 16];
    case (kind)
      LD_B:    value = {{24{byte_v[7]}}, byte_v};
      LD_BU:   value = {24'd0, byte_v};
      LD_H:    value = {{16{half_v[15]}}, half_v};
      LD_HU:   value = {16'd0, half_v};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage of the core. Issues at most one data-memory
// request per MEM phase, formats store lanes, extracts/extends loads.
//   clk, rstn          clock, synchronous active-low reset
//   state              core sequencer state; stage acts while state == MEM
//   instr              decoded instruction flags
//   result             effective byte address from execute
//   rs2_v / frs2_v     integer / FP store data
//   mem_read_enabled   access is a load
//   mem_write_enabled  access is a store
//   dmem               memory bus (master side)
//   load_value         extended load result, held until the next load
//   done               one-cycle stage-complete pulse
//   misaligned         qualifies done: access was rejected as misaligned
module memory_access
  import memory_access_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [2:0]             state,
  input  instructions_t          instr,
  input  logic [31:0]            result,
  input  logic [31:0]            rs2_v,
  input  logic [31:0]            frs2_v,
  input  logic                   mem_read_enabled,
  input  logic                   mem_write_enabled,
  memory_access_if.master        dmem,
  output logic [31:0]            load_value,
  output logic                   done,
  output logic                   misaligned
);

  mem_fsm_t    fsm;
  ld_kind_t    ld_kind_q;
  logic [1:0]  off_q;
  logic [31:0] ld_ext;
  logic [31:0] st_data;
  logic        mis;

  logic [NUM_LANES-1:0][LANE_W-1:0] wdata_fmt;
  logic [NUM_LANES-1:0]             wstrb_fmt;

  assign st_data = instr.fsw ? frs2_v : rs2_v;
  assign mis     = is_misaligned(instr, result[1:0]);

  // Store lane formatting from the live inputs; the result is registered
  // onto the bus when the request is launched, so it stays stable in REQ.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wdata_fmt[l] = instr.sb ? st_data[7:0] :
                          instr.sh ? st_data[8*(l%2) +: 8] :
                                     st_data[8*l +: 8];
    assign wstrb_fmt[l] = instr.sb ? (result[1:0] == 2'(l)) :
                          instr.sh ? (result[1] == 1'(l/2)) :
                                     1'b1;
  end

  load_align u_load_align (
    .kind  (ld_kind_q),
    .off   (off_q),
    .rdata (dmem.dmem_rdata),
    .value (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm                 <= S_IDLE;
      ld_kind_q           <= LD_W;
      off_q               <= 2'd0;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_we        <= 1'b0;
      dmem.dmem_wstrb     <= 4'd0;
      dmem.dmem_addr      <= 32'd0;
      dmem.dmem_wdata     <= 32'd0;
      load_value          <= 32'd0;
      done                <= 1'b0;
      misaligned          <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          if (state == MEM) begin
            if (mem_read_enabled || mem_write_enabled) begin
              // Only the load kind and byte offset are needed after launch;
              // everything else goes straight onto the bus registers.
              ld_kind_q <= load_kind(instr);
              off_q     <= result[1:0];
              if (mis) begin
                fsm        <= S_DONE;
                done       <= 1'b1;
                misaligned <= 1'b1;
              end else begin
                fsm                 <= S_REQ;
                dmem.dmem_req_valid <= 1'b1;
                dmem.dmem_we        <= mem_write_enabled;
                dmem.dmem_addr      <= {result[31:2], 2'b00};
                dmem.dmem_wdata     <= mem_write_enabled ? wdata_fmt : 32'd0;
                dmem.dmem_wstrb     <= mem_write_enabled ? wstrb_fmt : 4'd0;
              end
            end else begin
              fsm  <= S_DONE;
              done <= 1'b1;
            end
          end
        end
        // state leaving MEM here or in WAIT_R is ignored: the access completes.
        S_REQ: begin
          if (dmem.dmem_req_ready) begin
            dmem.dmem_req_valid <= 1'b0;
            if (dmem.dmem_we) begin
              fsm  <= S_DONE;
              done <= 1'b1;
            end else begin
              fsm <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (dmem.dmem_rvalid) begin
            load_value <= ld_ext;
            fsm        <= S_DONE;
            done       <= 1'b1;
          end
        end
        S_DONE: begin
          // Park here for the rest of the MEM phase so one phase never
          // issues a second access.
          done       <= 1'b0;
          misaligned <= 1'b0;
          if (state != MEM) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
  import memory_access_pkg::*;

  localparam int OP_LB = 0, OP_LH = 1, OP_LW = 2, OP_LBU = 3, OP_LHU = 4, OP_FLW = 5;
  localparam int OP_SB = 6, OP_SH = 7, OP_SW = 8, OP_FSW = 9, OP_NONE = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [2:0]    state = 3'd0;
  instructions_t instr = '0;
  logic [31:0]   result = 32'd0, rs2_v = 32'd0, frs2_v = 32'd0;
  logic          rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   load_value;
  logic          done, misaligned;

  memory_access_if dmem();

  memory_access dut (
    .clk               (clk),
    .rstn              (rstn),
    .state             (state),
    .instr             (instr),
    .result            (result),
    .rs2_v             (rs2_v),
    .frs2_v            (frs2_v),
    .mem_read_enabled  (rd_en),
    .mem_write_enabled (wr_en),
    .dmem              (dmem),
    .load_value        (load_value),
    .done              (done),
    .misaligned        (misaligned)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;

  typedef struct {
    logic        mis;
    logic        is_load;
    logic [31:0] lv;
    int          lat;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic instructions_t mk_instr(input int op);
    instructions_t i;
    i = '0;
    case (op)
      OP_LB:  i.lb  = 1'b1;
      OP_LH:  i.lh  = 1'b1;
      OP_LW:  i.lw  = 1'b1;
      OP_LBU: i.lbu = 1'b1;
      OP_LHU: i.lhu = 1'b1;
      OP_FLW: i.flw = 1'b1;
      OP_SB:  i.sb  = 1'b1;
      OP_SH:  i.sh  = 1'b1;
      OP_SW:  i.sw  = 1'b1;
      OP_FSW: i.fsw = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  function automatic logic mis_model(input int op, input logic [1:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0];
    if (op == OP_LW || op == OP_FLW || op == OP_SW || op == OP_FSW) return a != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld_model(input int op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> (a * 8);
    b  = sh[7:0];
    h  = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:  return {{24{b[7]}}, b};
      OP_LBU: return {24'd0, b};
      OP_LH:  return {{16{h[15]}}, h};
      OP_LHU: return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  function automatic req_exp_t st_model(input int op, input logic [31:0] addr, input logic [31:0] d);
    req_exp_t r;
    int a;
    a = int'(addr[1:0]);
    r.addr = {addr[31:2], 2'b00};
    r.we   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (op == OP_SB)      r.wstrb[k] = (k == a);
      else if (op == OP_SH) r.wstrb[k] = (k == a) || (k == a + 1);
      else                  r.wstrb[k] = 1'b1;
    end
    if (op == OP_SB)      r.wdata = {4{d[7:0]}};
    else if (op == OP_SH) r.wdata = {2{d[15:0]}};
    else                  r.wdata = d;
    return r;
  endfunction

  // One MEM phase: push expectations, drive the op, act as the memory,
  // and keep state at MEM well past done to catch any re-trigger.
  task automatic do_op(input string nm, input int op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rdata,
                       input int rdy_from, input int rv_dly);
    bit          ld, st, mis, accepted;
    int          acc_c, lat, ndone, nacc, rv_at;
    logic [31:0] lv_before;
    req_exp_t    re;
    done_exp_t   de;
    ld  = (op <= OP_FLW);
    st  = (op >= OP_SB && op <= OP_FSW);
    mis = mis_model(op, addr[1:0]);
    acc_c = (rdy_from < 1) ? 1 : rdy_from;
    if (mis || !(ld || st)) lat = 1;
    else if (st)            lat = acc_c + 1;
    else                    lat = acc_c + 2 + rv_dly;
    ndone = 0; nacc = 0; rv_at = -1; accepted = 0;
    req_q.delete();
    done_q.delete();
    if ((ld || st) && !mis) begin
      if (st) re = st_model(op, addr, data);
      else begin
        re.addr = {addr[31:2], 2'b00}; re.we = 1'b0; re.wdata = '0; re.wstrb = '0;
      end
      req_q.push_back(re);
    end
    de.mis = mis; de.is_load = ld && !mis; de.lv = ld_model(op, addr[1:0], rdata); de.lat = lat;
    done_q.push_back(de);
    lv_before = load_value;

    @(posedge clk); #2;
    instr  = mk_instr(op);
    result = addr;
    rd_en  = ld;
    wr_en  = st;
    rs2_v  = (op == OP_FSW) ? ~data : data;
    frs2_v = (op == OP_FSW) ? data : ~data;
    state  = MEM;
    dmem.dmem_req_ready = (rdy_from == 0);
    dmem.dmem_rvalid    = 1'b0;
    dmem.dmem_rdata     = rdata;
    for (int c = 0; c < lat + 7; c++) begin
      @(negedge clk);
      if (dmem.dmem_req_valid) begin
        if (req_q.size() == 0) chk({nm, ".unexp_req"}, dmem.dmem_req_valid, 1'b0);
        else begin
          re = req_q[0];
          chk({nm, ".addr"}, dmem.dmem_addr, re.addr);
          chk({nm, ".we"}, dmem.dmem_we, re.we);
          if (re.we) begin
            chk({nm, ".wstrb"}, dmem.dmem_wstrb, re.wstrb);
            chk({nm, ".wdata"}, dmem.dmem_wdata, re.wdata);
          end
          if (dmem.dmem_req_ready) begin
            void'(req_q.pop_front());
            nacc++;
            accepted = 1;
            chk({nm, ".acc_cyc"}, c, acc_c);
            // stores also get a stray rvalid; it must be ignored
            rv_at = c + 1 + rv_dly;
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk({nm, ".extra_done"}, done, 1'b0);
        else begin
          de = done_q.pop_front();
          ndone++;
          chk({nm, ".latency"}, c, de.lat);
          chk({nm, ".misaligned"}, misaligned, de.mis);
          if (de.is_load) chk({nm, ".load_value"}, load_value, de.lv);
        end
      end else begin
        chk({nm, ".mis_idle"}, misaligned, 1'b0);
      end
      @(posedge clk); #2;
      dmem.dmem_req_ready = !accepted && (c + 1 >= rdy_from);
      dmem.dmem_rvalid    = (c + 1 == rv_at);
    end
    chk({nm, ".done_count"}, ndone, 1);
    chk({nm, ".req_count"}, nacc, ((ld || st) && !mis) ? 1 : 0);
    if (!(ld && !mis)) chk({nm, ".lv_hold"}, load_value, lv_before);
    state = 3'd1; rd_en = 1'b0; wr_en = 1'b0;
    dmem.dmem_req_ready = 1'b0; dmem.dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Reset lands while the load waits for its response; the late rvalid
  // must be dropped.
  task automatic reset_mid();
    @(posedge clk); #2;
    instr = mk_instr(OP_LW); result = 32'h0000_0400; rd_en = 1'b1; wr_en = 1'b0;
    state = MEM; dmem.dmem_req_ready = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #2;               // REQ, accepted at next edge
    @(posedge clk); #2;               // WAIT_R
    chk("rst.in_wait", dmem.dmem_req_valid, 1'b0);
    dmem.dmem_req_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1; state = 3'd1; rd_en = 1'b0;
    dmem.dmem_rvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst.no_done", done, 1'b0);
      @(posedge clk); #2;
      dmem.dmem_rvalid = 1'b0;
    end
    chk("rst.load_value", load_value, 32'd0);
    chk("rst.fsm_idle", dut.fsm, S_IDLE);
    chk("rst.req_valid", dmem.dmem_req_valid, 1'b0);
  endtask

  initial begin
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rvalid    = 1'b0;
    dmem.dmem_rdata     = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.req_valid", dmem.dmem_req_valid, 1'b0);
    chk("reset.we", dmem.dmem_we, 1'b0);
    chk("reset.wstrb", dmem.dmem_wstrb, 4'd0);
    chk("reset.addr", dmem.dmem_addr, 32'd0);
    chk("reset.wdata", dmem.dmem_wdata, 32'd0);
    chk("reset.load_value", load_value, 32'd0);
    chk("reset.done", done, 1'b0);
    chk("reset.misaligned", misaligned, 1'b0);
    rstn = 1'b1;
    state = 3'd1;
    repeat (2) @(posedge clk);

    do_op("sb",   OP_SB,  32'h0000_0103, 32'h0000_00AB, 32'h0,          0, 0);
    do_op("lb",   OP_LB,  32'h0000_0202, 32'h0,          32'h12F4_5678, 0, 0);
    chk("lb.spec", load_value, 32'hFFFF_FFF4);
    do_op("lbu",  OP_LBU, 32'h0000_0202, 32'h0,          32'h12F4_5678, 0, 0);
    chk("lbu.spec", load_value, 32'h0000_00F4);
    do_op("lw_mis", OP_LW, 32'h0000_0301, 32'h0,         32'h1111_2222, 0, 0);
    do_op("flw",  OP_FLW, 32'h0000_0304, 32'h0,          32'h3F80_0000, 4, 2);
    chk("flw.spec", load_value, 32'h3F80_0000);
    do_op("sh",   OP_SH,  32'h0000_0102, 32'h1234_BEEF, 32'h0,          0, 0);
    do_op("sh_mis", OP_SH, 32'h0000_0101, 32'h1234_BEEF, 32'h0,         0, 0);
    do_op("lh",   OP_LH,  32'h0000_0206, 32'h0,          32'h8001_7FFF, 1, 1);
    do_op("lhu",  OP_LHU, 32'h0000_0204, 32'h0,          32'h8001_FFFF, 0, 0);
    do_op("lhu_mis", OP_LHU, 32'h0000_0203, 32'h0,       32'h8001_FFFF, 0, 0);
    do_op("sw",   OP_SW,  32'h0000_010C, 32'hCAFE_F00D, 32'h0,          0, 0);
    do_op("fsw",  OP_FSW, 32'h0000_0110, 32'h4049_0FDB, 32'h0,          2, 0);
    do_op("none", OP_NONE, 32'h0000_0123, 32'h0,         32'h0,          0, 0);
    for (int i = 0; i < 10; i++)
      do_op("rand", $urandom_range(0, 10), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2));
    do_op("lw_pre_rst", OP_LW, 32'h0000_0500, 32'h0, 32'h7654_3210, 0, 0);
    reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
